// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants, types and helpers for the pipeline hazard controller.
package hazard_stall_ctrl_pkg;

  // Primary opcodes (insn[31:27])
  localparam logic [4:0] RTYPE = 5'b00000;
  localparam logic [4:0] J     = 5'b00001;
  localparam logic [4:0] BNE   = 5'b00010;
  localparam logic [4:0] JAL   = 5'b00011;
  localparam logic [4:0] JR    = 5'b00100;
  localparam logic [4:0] ADDI  = 5'b00101;
  localparam logic [4:0] BLT   = 5'b00110;
  localparam logic [4:0] SW    = 5'b00111;
  localparam logic [4:0] LW    = 5'b01000;
  localparam logic [4:0] SETX  = 5'b10101;
  localparam logic [4:0] BEX   = 5'b10110;

  // R-type ALU ops (insn[6:2]) handled by the multdiv unit
  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  // Architectural registers with fixed roles
  localparam logic [4:0] R0  = 5'd0;
  localparam logic [4:0] R30 = 5'd30;
  localparam logic [4:0] R31 = 5'd31;

  // ALU operand source selects
  localparam logic [1:0] BYP_RF = 2'b00;
  localparam logic [1:0] BYP_XM = 2'b01;
  localparam logic [1:0] BYP_MW = 2'b10;

  // Multdiv sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MD_START = 2'b01,
    MD_BUSY  = 2'b10,
    MD_DONE  = 2'b11
  } md_state_t;

  // Register usage of one pipeline latch
  typedef struct packed {
    logic [4:0] dest;
    logic       dest_valid;
    logic [4:0] src_a;
    logic       src_a_valid;
    logic [4:0] src_b;
    logic       src_b_valid;
    logic       is_lw;
    logic       is_md;
    logic       is_div;
  } insn_regs_t;

  // True when a valid source reads the register a valid writer produces; $r0 never matches
  function automatic logic reg_match(input logic [4:0] src, input logic src_valid,
                                     input logic [4:0] dst, input logic dst_valid);
    return src_valid && dst_valid && (src != R0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_insn_regs_decode.sv
// Extracts destination/source registers and multi-cycle flags from one instruction word.
module insn_regs_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output logic [4:0]  dest,
  output logic        dest_valid,
  output logic [4:0]  src_a,
  output logic        src_a_valid,
  output logic [4:0]  src_b,
  output logic        src_b_valid,
  output logic        is_lw,
  output logic        is_md,
  output logic        is_div
);

  logic [4:0] opcode_s;
  logic [4:0] alu_op_s;
  logic [4:0] rd_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       unused_s;

  assign opcode_s = insn[31:27];
  assign rd_s     = insn[26:22];
  assign rs_s     = insn[21:17];
  assign rt_s     = insn[16:12];
  assign alu_op_s = insn[6:2];
  assign unused_s = ^{insn[11:7], insn[1:0]};

  // Classify the instruction into its register reads, register write and multdiv use
  always_comb begin
    dest        = R0;
    dest_valid  = 1'b0;
    src_a       = R0;
    src_a_valid = 1'b0;
    src_b       = R0;
    src_b_valid = 1'b0;
    is_lw       = 1'b0;
    is_md       = 1'b0;
    is_div      = 1'b0;
    case (opcode_s)
      RTYPE: begin
        dest        = rd_s;
        dest_valid  = (insn != 32'h0000_0000);  // all-zero word is a nop
        src_a       = rs_s;
        src_a_valid = 1'b1;
        src_b       = rt_s;
        src_b_valid = 1'b1;
        is_md       = (alu_op_s == MUL) || (alu_op_s == DIV);
        is_div      = (alu_op_s == DIV);
      end
      ADDI: begin
        dest        = rd_s;
        dest_valid  = 1'b1;
        src_a       = rs_s;
        src_a_valid = 1'b1;
      end
      LW: begin
        dest        = rd_s;
        dest_valid  = 1'b1;
        src_a       = rs_s;
        src_a_valid = 1'b1;
        is_lw       = 1'b1;
      end
      SW, BNE, BLT: begin
        src_a       = rs_s;
        src_a_valid = 1'b1;
        src_b       = rd_s;
        src_b_valid = 1'b1;
      end
      JR: begin
        src_b       = rd_s;
        src_b_valid = 1'b1;
      end
      BEX: begin
        src_b       = R30;
        src_b_valid = 1'b1;
      end
      JAL: begin
        dest        = R31;
        dest_valid  = 1'b1;
      end
      SETX: begin
        dest        = R30;
        dest_valid  = 1'b1;
      end
      default: begin
        dest_valid  = 1'b0;  // j and unknown opcodes touch no registers
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: stalls, squashes, operand bypass, multdiv sequencing and perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic [31:0]      xm_insn,
  input  logic [31:0]      mw_insn,
  input  logic             branch_taken,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             squash_fd,
  output logic             squash_dx,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_sel,
  output logic             md_err,
  output logic [1:0]       bypA_sel,
  output logic [1:0]       bypB_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MD_CNT_W = $clog2(MD_MAX_CYCLES + 1);
  localparam int STG_FD   = 0;
  localparam int STG_DX   = 1;
  localparam int STG_XM   = 2;
  localparam int STG_MW   = 3;

  logic [31:0]        insn_s [4];
  insn_regs_t         dec_s  [4];

  md_state_t          state_r;
  md_state_t          state_nxt_s;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic               md_err_r;
  logic               ctrl_mult_r;
  logic               ctrl_div_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;

  logic               load_use_s;
  logic               md_go_s;
  logic               md_timeout_s;
  logic               md_hold_s;
  logic               md_sel_s;
  logic               stall_fd_s;
  logic               unused_s;

  assign insn_s[STG_FD] = fd_insn;
  assign insn_s[STG_DX] = dx_insn;
  assign insn_s[STG_XM] = xm_insn;
  assign insn_s[STG_MW] = mw_insn;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    insn_regs_decode u_dec (
      .insn        (insn_s[g]),
      .dest        (dec_s[g].dest),
      .dest_valid  (dec_s[g].dest_valid),
      .src_a       (dec_s[g].src_a),
      .src_a_valid (dec_s[g].src_a_valid),
      .src_b       (dec_s[g].src_b),
      .src_b_valid (dec_s[g].src_b_valid),
      .is_lw       (dec_s[g].is_lw),
      .is_md       (dec_s[g].is_md),
      .is_div      (dec_s[g].is_div)
    );
  end

  // Not every stage needs every decoded field
  assign unused_s = ^{dec_s[STG_FD], dec_s[STG_XM], dec_s[STG_MW]};

  // Operand source: X/M result first (unless it is a load), then M/W writeback, else regfile
  function automatic logic [1:0] byp_sel(input logic [4:0] src, input logic src_valid,
                                         input insn_regs_t xm, input insn_regs_t mw);
    logic [1:0] sel;
    if (reg_match(src, src_valid, xm.dest, xm.dest_valid) && !xm.is_lw) begin
      sel = BYP_XM;
    end else if (reg_match(src, src_valid, mw.dest, mw.dest_valid)) begin
      sel = BYP_MW;
    end else begin
      sel = BYP_RF;
    end
    return sel;
  endfunction

  // Load-use detection, multdiv launch condition and busy timeout
  always_comb begin
    load_use_s   = dec_s[STG_DX].is_lw &&
                   (reg_match(dec_s[STG_FD].src_a, dec_s[STG_FD].src_a_valid,
                              dec_s[STG_DX].dest,  dec_s[STG_DX].dest_valid) ||
                    reg_match(dec_s[STG_FD].src_b, dec_s[STG_FD].src_b_valid,
                              dec_s[STG_DX].dest,  dec_s[STG_DX].dest_valid));
    md_go_s      = (state_r == IDLE) && dec_s[STG_DX].is_md && !branch_taken;
    md_timeout_s = (md_cnt_r == MD_CNT_W'(MD_MAX_CYCLES - 1));
  end

  // Multdiv FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Multdiv FSM next state; md_ready is only honoured while busy
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (md_go_s) begin
          state_nxt_s = MD_START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MD_START: begin
        state_nxt_s = MD_BUSY;
      end
      MD_BUSY: begin
        if (md_ready || md_timeout_s) begin
          state_nxt_s = MD_DONE;
        end else begin
          state_nxt_s = MD_BUSY;
        end
      end
      MD_DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Multdiv FSM outputs: front-end hold (including the launch cycle) and result select
  always_comb begin
    md_hold_s = 1'b0;
    md_sel_s  = 1'b0;
    case (state_r)
      IDLE: begin
        md_hold_s = md_go_s;  // keep the mul/div in D/X while it launches
      end
      MD_START, MD_BUSY: begin
        md_hold_s = 1'b1;
      end
      MD_DONE: begin
        md_sel_s  = 1'b1;
      end
      default: begin
        md_hold_s = 1'b0;
      end
    endcase
  end

  // Pipeline control outputs; a taken redirect wins over the load-use stall
  always_comb begin
    stall_fd_s  = 1'b0;
    stall_fd    = 1'b0;
    stall_dx    = 1'b0;
    squash_fd   = 1'b0;
    squash_dx   = 1'b0;
    ctrl_mult   = 1'b0;
    ctrl_div    = 1'b0;
    md_sel      = 1'b0;
    md_err      = 1'b0;
    bypA_sel    = BYP_RF;
    bypB_sel    = BYP_RF;
    stall_count = {CNT_W{1'b0}};
    flush_count = {CNT_W{1'b0}};
    if (reset) begin
      stall_fd_s = 1'b0;
    end else begin
      stall_fd_s  = md_hold_s || (load_use_s && !branch_taken);
      stall_fd    = stall_fd_s;
      stall_dx    = md_hold_s;
      squash_fd   = branch_taken;
      squash_dx   = branch_taken || load_use_s;
      ctrl_mult   = ctrl_mult_r;
      ctrl_div    = ctrl_div_r;
      md_sel      = md_sel_s;
      md_err      = md_sel_s && md_err_r;
      bypA_sel    = byp_sel(dec_s[STG_DX].src_a, dec_s[STG_DX].src_a_valid,
                            dec_s[STG_XM], dec_s[STG_MW]);
      bypB_sel    = byp_sel(dec_s[STG_DX].src_b, dec_s[STG_DX].src_b_valid,
                            dec_s[STG_XM], dec_s[STG_MW]);
      stall_count = stall_cnt_r;
      flush_count = flush_cnt_r;
    end
  end

  // Multdiv start pulses, busy cycle counter and latched error
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_mult_r <= 1'b0;
      ctrl_div_r  <= 1'b0;
      md_cnt_r    <= {MD_CNT_W{1'b0}};
      md_err_r    <= 1'b0;
    end else begin
      ctrl_mult_r <= md_go_s && !dec_s[STG_DX].is_div;
      ctrl_div_r  <= md_go_s &&  dec_s[STG_DX].is_div;
      case (state_r)
        MD_START: begin
          md_cnt_r <= {MD_CNT_W{1'b0}};
          md_err_r <= 1'b0;
        end
        MD_BUSY: begin
          md_cnt_r <= md_cnt_r + MD_CNT_W'(1);
          if (md_ready) begin
            md_err_r <= md_exception;
          end else if (md_timeout_s) begin
            md_err_r <= 1'b1;
          end else begin
            md_err_r <= md_err_r;
          end
        end
        default: begin
          md_cnt_r <= md_cnt_r;
        end
      endcase
    end
  end

  // Saturating stall-cycle and redirect counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_fd_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (branch_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

  localparam logic [4:0] OP_R = 5'b00000, OP_BNE = 5'b00010, OP_JAL = 5'b00011,
                         OP_JR = 5'b00100, OP_ADDI = 5'b00101, OP_SW = 5'b00111,
                         OP_LW = 5'b01000, OP_SETX = 5'b10101, OP_BEX = 5'b10110;
  localparam logic [4:0] F_ADD = 5'b00000, F_SUB = 5'b00001, F_MUL = 5'b00110, F_DIV = 5'b00111;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] fd_insn, dx_insn, xm_insn, mw_insn;
  logic        branch_taken, md_ready, md_exception;
  logic        stall_fd, stall_dx, squash_fd, squash_dx, ctrl_mult, ctrl_div, md_sel, md_err;
  logic [1:0]  bypA_sel, bypB_sel;
  logic [31:0] stall_count, flush_count;
  logic [11:0] all_out;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_ctrl #(.MD_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn), .mw_insn(mw_insn),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .stall_fd(stall_fd), .stall_dx(stall_dx), .squash_fd(squash_fd), .squash_dx(squash_dx),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_sel(md_sel), .md_err(md_err),
    .bypA_sel(bypA_sel), .bypB_sel(bypB_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign all_out = {stall_fd, stall_dx, squash_fd, squash_dx, ctrl_mult, ctrl_div,
                    md_sel, md_err, bypA_sel, bypB_sel};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_insn(input logic [4:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {OP_R, rd, rs, rt, 5'b00000, fn, 2'b00};
  endfunction

  function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] j_insn(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] fd, dx, xm, mw;
    logic        bt;
    logic        s_fd, s_dx, q_fd, q_dx;
    logic [1:0]  ba, bb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [31:0] fd, input logic [31:0] dx,
                              input logic [31:0] xm, input logic [31:0] mw, input logic bt,
                              input logic s_fd, input logic s_dx, input logic q_fd,
                              input logic q_dx, input logic [1:0] ba, input logic [1:0] bb);
    vec_t v;
    v.name = n; v.fd = fd; v.dx = dx; v.xm = xm; v.mw = mw; v.bt = bt;
    v.s_fd = s_fd; v.s_dx = s_dx; v.q_fd = q_fd; v.q_dx = q_dx; v.ba = ba; v.bb = bb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nops();
    fd_insn = NOP; dx_insn = NOP; xm_insn = NOP; mw_insn = NOP;
    branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_nops();
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Launch a mul/div and follow it to MD_DONE; ready_at = busy cycle carrying md_ready (0 = never)
  task automatic md_run(input string tag, input bit is_div, input int ready_at, input bit exc,
                        input int exp_busy, input bit exp_err);
    int busy;
    int bad;
    busy = 0;
    bad  = 0;
    set_nops();
    dx_insn = is_div ? r_insn(F_DIV, 5'd3, 5'd1, 5'd2) : r_insn(F_MUL, 5'd3, 5'd1, 5'd2);
    #1;
    chk({tag, "_launch_hold"}, {30'd0, stall_fd, stall_dx}, 32'd3);
    chk({tag, "_launch_noctrl"}, {30'd0, ctrl_mult, ctrl_div}, 32'd0);
    step();
    md_ready = 1'b1;      // must be ignored in MD_START
    md_exception = 1'b1;
    #1;
    chk({tag, "_start_ctrl"}, {30'd0, ctrl_mult, ctrl_div}, is_div ? 32'd1 : 32'd2);
    chk({tag, "_start_hold"}, {30'd0, stall_fd, stall_dx}, 32'd3);
    step();
    md_ready = 1'b0;
    md_exception = 1'b0;
    while (md_sel !== 1'b1 && busy < 100) begin
      busy++;
      md_ready = (busy == ready_at);
      md_exception = exc && (busy == ready_at);
      #1;
      if ({stall_fd, stall_dx, ctrl_mult, ctrl_div} !== 4'b1100) bad++;
      step();
      md_ready = 1'b0;
      md_exception = 1'b0;
    end
    chk({tag, "_busy_cycles"}, busy, exp_busy);
    chk({tag, "_busy_bad_cycles"}, bad, 32'd0);
    chk({tag, "_done_sel"}, {31'd0, md_sel}, 32'd1);
    chk({tag, "_done_err"}, {31'd0, md_err}, {31'd0, exp_err});
    chk({tag, "_done_release"}, {30'd0, stall_fd, stall_dx}, 32'd0);
    step();
    dx_insn = NOP;
    #1;
    chk({tag, "_after_idle"}, {29'd0, md_sel, stall_fd, stall_dx}, 32'd0);
  endtask

  initial begin
    int stray;

    // fd, dx, xm, mw, bt | stall_fd stall_dx squash_fd squash_dx bypA bypB
    vecs.push_back(mk("xm_bypass_ab", NOP, r_insn(F_SUB,5'd4,5'd1,5'd1), r_insn(F_ADD,5'd1,5'd2,5'd3), NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b01));
    vecs.push_back(mk("mw_bypass_a", NOP, r_insn(F_SUB,5'd4,5'd1,5'd2), NOP, r_insn(F_ADD,5'd1,5'd2,5'd3), 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b10, 2'b00));
    vecs.push_back(mk("xm_priority", NOP, r_insn(F_ADD,5'd5,5'd1,5'd1), i_insn(OP_ADDI,5'd1,5'd2,17'd7),
                      r_insn(F_ADD,5'd1,5'd3,5'd3), 1'b0, 1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b01));
    vecs.push_back(mk("r0_never", NOP, r_insn(F_ADD,5'd3,5'd0,5'd0), i_insn(OP_ADDI,5'd0,5'd2,17'd5),
                      i_insn(OP_ADDI,5'd0,5'd2,17'd5), 1'b0, 1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));
    vecs.push_back(mk("lw_xm_no_byp", NOP, r_insn(F_ADD,5'd7,5'd5,5'd0), i_insn(OP_LW,5'd5,5'd6,17'd0), NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));
    vecs.push_back(mk("lw_mw_byp", NOP, r_insn(F_ADD,5'd7,5'd5,5'd0), NOP, i_insn(OP_LW,5'd5,5'd6,17'd0), 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b10, 2'b00));
    vecs.push_back(mk("sw_store_data", NOP, i_insn(OP_SW,5'd9,5'd2,17'd4), r_insn(F_ADD,5'd9,5'd1,5'd1),
                      i_insn(OP_ADDI,5'd2,5'd3,17'd1), 1'b0, 1'b0,1'b0,1'b0,1'b0, 2'b10, 2'b01));
    vecs.push_back(mk("bex_r30", NOP, j_insn(OP_BEX,27'd0), j_insn(OP_SETX,27'd5), NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b01));
    vecs.push_back(mk("jr_r31", NOP, i_insn(OP_JR,5'd31,5'd0,17'd0), NOP, j_insn(OP_JAL,27'd100), 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b10));
    vecs.push_back(mk("bne_ab", NOP, i_insn(OP_BNE,5'd4,5'd5,17'd0), i_insn(OP_ADDI,5'd5,5'd1,17'd1),
                      i_insn(OP_ADDI,5'd4,5'd1,17'd1), 1'b0, 1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b10));
    vecs.push_back(mk("addi_no_b", NOP, i_insn(OP_ADDI,5'd3,5'd2,17'h01000), r_insn(F_ADD,5'd1,5'd4,5'd4), NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));
    vecs.push_back(mk("load_use", r_insn(F_ADD,5'd7,5'd5,5'd0), i_insn(OP_LW,5'd5,5'd6,17'd0), NOP, NOP, 1'b0,
                      1'b1,1'b0,1'b0,1'b1, 2'b00, 2'b00));
    vecs.push_back(mk("load_use_r0", r_insn(F_ADD,5'd7,5'd0,5'd0), i_insn(OP_LW,5'd0,5'd6,17'd0), NOP, NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));
    vecs.push_back(mk("load_use_sw", i_insn(OP_SW,5'd8,5'd1,17'd0), i_insn(OP_LW,5'd8,5'd2,17'd0), NOP, NOP, 1'b0,
                      1'b1,1'b0,1'b0,1'b1, 2'b00, 2'b00));
    vecs.push_back(mk("no_load_use", r_insn(F_ADD,5'd7,5'd6,5'd6), i_insn(OP_LW,5'd5,5'd6,17'd0), NOP, NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));
    vecs.push_back(mk("load_use_redirect", r_insn(F_ADD,5'd7,5'd5,5'd0), i_insn(OP_LW,5'd5,5'd6,17'd0), NOP, NOP, 1'b1,
                      1'b0,1'b0,1'b1,1'b1, 2'b00, 2'b00));
    vecs.push_back(mk("redirect", NOP, NOP, NOP, NOP, 1'b1,
                      1'b0,1'b0,1'b1,1'b1, 2'b00, 2'b00));
    vecs.push_back(mk("mul_redirect", NOP, r_insn(F_MUL,5'd3,5'd1,5'd2), NOP, NOP, 1'b1,
                      1'b0,1'b0,1'b1,1'b1, 2'b00, 2'b00));
    vecs.push_back(mk("all_nop", NOP, NOP, NOP, NOP, 1'b0,
                      1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00));

    // Reset with live hazards on the inputs: everything must read zero
    reset = 1'b1;
    set_nops();
    fd_insn = r_insn(F_ADD, 5'd7, 5'd5, 5'd0);
    dx_insn = i_insn(OP_LW, 5'd5, 5'd6, 17'd0);
    xm_insn = r_insn(F_ADD, 5'd6, 5'd1, 5'd1);
    branch_taken = 1'b1;
    #1;
    chk("reset_outputs_during", {20'd0, all_out}, 32'd0);
    step();
    step();
    chk("reset_outputs_held", {20'd0, all_out}, 32'd0);
    chk("reset_counts_held", stall_count | flush_count, 32'd0);
    reset = 1'b0;
    set_nops();
    #1;
    chk("reset_outputs_after", {20'd0, all_out}, 32'd0);
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_flush_count", flush_count, 32'd0);

    // Combinational stall/squash/bypass table
    foreach (vecs[i]) begin
      fd_insn = vecs[i].fd; dx_insn = vecs[i].dx; xm_insn = vecs[i].xm; mw_insn = vecs[i].mw;
      branch_taken = vecs[i].bt;
      #1;
      chk({vecs[i].name, "/stall_fd"},  {31'd0, stall_fd},  {31'd0, vecs[i].s_fd});
      chk({vecs[i].name, "/stall_dx"},  {31'd0, stall_dx},  {31'd0, vecs[i].s_dx});
      chk({vecs[i].name, "/squash_fd"}, {31'd0, squash_fd}, {31'd0, vecs[i].q_fd});
      chk({vecs[i].name, "/squash_dx"}, {31'd0, squash_dx}, {31'd0, vecs[i].q_dx});
      chk({vecs[i].name, "/bypA_sel"},  {30'd0, bypA_sel},  {30'd0, vecs[i].ba});
      chk({vecs[i].name, "/bypB_sel"},  {30'd0, bypB_sel},  {30'd0, vecs[i].bb});
      step();
    end
    set_nops();
    #1;
    chk("table_stall_count", stall_count, 32'd2);
    chk("table_flush_count", flush_count, 32'd3);

    // mul with md_ready in busy cycle 33: 35 stalled cycles
    do_reset();
    md_run("mul33", 1'b0, 33, 1'b0, 33, 1'b0);
    chk("mul33_stall_count", stall_count, 32'd35);
    chk("mul33_flush_count", flush_count, 32'd0);
    md_run("mul_exc", 1'b0, 1, 1'b1, 1, 1'b1);
    md_run("div_timeout", 1'b1, 0, 1'b0, 40, 1'b1);
    md_run("mul_after_to", 1'b0, 5, 1'b0, 5, 1'b0);
    chk("md_total_stall_count", stall_count, 32'd87);

    // Reset in busy cycle 10 abandons the div
    do_reset();
    dx_insn = r_insn(F_DIV, 5'd3, 5'd1, 5'd2);
    step();                          // MD_START
    for (int k = 1; k <= 10; k++) step();  // now in busy cycle 10
    chk("pre_reset_busy_hold", {30'd0, stall_fd, stall_dx}, 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {20'd0, all_out}, 32'd0);
    step();
    reset = 1'b0;
    dx_insn = NOP;
    #1;
    chk("post_reset_outputs", {20'd0, all_out}, 32'd0);
    chk("post_reset_stall_count", stall_count, 32'd0);
    chk("post_reset_flush_count", flush_count, 32'd0);
    stray = 0;
    for (int k = 0; k < 50; k++) begin
      if ({ctrl_mult, ctrl_div, md_sel, stall_fd} !== 4'b0000) stray++;
      step();
    end
    chk("post_reset_no_stray", stray, 32'd0);
    chk("post_reset_stall_idle", stall_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipelined core. It watches the F/D, D/X, X/M and M/W instruction latches and generates PC/latch stall enables, squash (nop-insert) controls and ALU operand bypass selects. It also runs the multi-cycle mult/div handshake that holds the front of the pipeline while the multdiv unit works. It keeps saturating performance counters for stalls and flushes.

Parameters:
MD_MAX_CYCLES, 40, cycles allowed in MD_BUSY before timeout.
CNT_W, 32, width of the performance counters.

Ports:
clock  in  1  master clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
fd_insn  in  32  F/D latch instruction
dx_insn  in  32  D/X latch instruction
xm_insn  in  32  X/M latch instruction
mw_insn  in  32  M/W latch instruction
branch_taken  in  1  execute-stage redirect (bne/blt taken, j, jal, jr, bex taken)
md_ready  in  1  multdiv result valid; one-cycle pulse
md_exception  in  1  multdiv exception; sampled only with md_ready
stall_fd  out  1  hold PC and F/D latch
stall_dx  out  1  hold D/X latch
squash_fd  out  1  load nop into F/D next edge
squash_dx  out  1  load nop into D/X next edge
ctrl_mult  out  1  one-cycle mult start pulse
ctrl_div  out  1  one-cycle div start pulse
md_sel  out  1  X/M O-latch takes the multdiv result instead of the ALU result
md_err  out  1  multdiv exception or timeout; valid with md_sel
bypA_sel  out  2  ALU A source: 00 regfile, 01 X/M O, 10 M/W writeback data
bypB_sel  out  2  ALU B / store data source, same encoding as bypA_sel
stall_count  out  CNT_W  cycles with stall_fd=1, saturating
flush_count  out  CNT_W  taken redirects, saturating

Behaviour:
- Opcode is insn[31:27]; R-type ALU op is insn[6:2]; mul is R-type op 00110, div is R-type op 00111.
- Writers and their destination:
  - R-type, addi (00101), lw (01000): rd = insn[26:22].
  - jal (00011): $r31.
  - setx (10101): $r30.
  - An all-zero word is a nop and does not write.
- Readers and their source registers:
  - R-type: rs [21:17], rt [16:12].
  - addi, lw: rs.
  - sw (00111): rs plus rd as store data (B path).
  - bne (00010), blt (00110): rd on B path, rs on A path.
  - jr (00100): rd on B path.
  - bex (10110): $r30 on B path.
- Bypass:
  - Compare each dx_insn source against the xm_insn destination first, then the mw_insn destination. X/M has priority.
  - $r0 never matches.
  - A lw in X/M is not a bypass source; the load-use stall covers it.
- Load-use: dx_insn is lw, and an fd_insn source equals its rd (not $r0). Result: stall_fd=1 and squash_dx=1 for exactly one cycle.
- Redirect: branch_taken=1 gives squash_fd=1 and squash_dx=1 in the same cycle.
  - Overrides a load-use stall: stall_fd=0 so the new PC loads.
- Multdiv FSM, states IDLE, MD_START, MD_BUSY, MD_DONE:
  - IDLE: dx_insn is mul/div and branch_taken=0. Go to MD_START.
  - MD_START: drive ctrl_mult or ctrl_div for one cycle. stall_fd=stall_dx=1. Go to MD_BUSY, cycle counter = 0.
  - MD_BUSY: stall_fd=stall_dx=1, counter increments.
    - md_ready=1: go to MD_DONE; latch md_exception.
    - Counter reaches MD_MAX_CYCLES: go to MD_DONE with the error flag set.
  - MD_DONE: one cycle with md_sel=1 and md_err=latched flag. Stalls released, so the mul/div advances to X/M. Return to IDLE.
  - md_ready in the same cycle as MD_START: ignored. The unit's result appears no earlier than one cycle after start.
  - Back-to-back mul/div: the second sees IDLE only after MD_DONE. There is no restart while busy.
- Counters:
  - stall_count increments on every cycle with stall_fd=1.
  - flush_count increments on every cycle with branch_taken=1.
  - Both saturate at all-ones.
- Reset:
  - State goes to IDLE; counters and the latched error clear.
  - All outputs 0 during and after reset.
  - Reset mid-MD_BUSY abandons the operation; no ctrl pulse is issued.
- Latency: stall, squash and bypass outputs are combinational from the latch contents and FSM state. ctrl_mult and ctrl_div come from a register (MD_START).

Decomposition:
- Shared package holds:
  - opcode constants: RTYPE, ADDI, LW, SW, BNE, BLT, J, JAL, JR, BEX, SETX.
  - ALU op constants: MUL, DIV.
  - register constants: R0, R30, R31.
  - FSM state typedef.
  - bypass select encodings.
- Sub-module insn_regs_decode (insn -> dest, dest_valid, srcA, srcA_valid, srcB, srcB_valid, is_lw, is_md). Instantiated four times.

Test Plan:
1. add $r1,$r2,$r3 in X/M; sub $r4,$r1,$r1 in D/X -> bypA_sel=01, bypB_sel=01, no stall.
2. lw $r5,0($r6) in D/X; add $r7,$r5,$r0 in F/D -> stall_fd=1 and squash_dx=1 for one cycle; next cycle, with lw in X/M and add in D/X, both 0.
3. lw hazard as in 2, plus branch_taken=1 in the same cycle -> squash_fd=squash_dx=1, stall_fd=0, flush_count +1.
4. mul in D/X, md_ready after 33 cycles -> ctrl_mult one pulse, stall_fd=1 for 35 cycles, then md_sel=1 for one cycle, md_err=0, stall_count=35.
5. div in D/X, md_ready never arrives -> MD_DONE after 40 cycles in MD_BUSY, md_err=1, pipeline resumes.
6. reset asserted in MD_BUSY cycle 10 -> next edge state IDLE, all outputs and counters 0, no stray ctrl_div.
